// File: rtl/accel_tilt_seq.sv
// accel_tilt_seq: sequences two CORDIC vectoring requests to turn one accelerometer
// sample into roll and pitch angles.
//
//   roll  = atan2(ay, az)                  (request 1: x = az, y = ay)
//   pitch = atan2(-ax, |(ay, az)| / gain)  (request 2: x = compensated magnitude, y = -ax)
//
// Ports
//   clk, rst                  single rising-edge clock, asynchronous active-high reset
//   sample_valid, ax/ay/az    one-cycle strobe with signed 16-bit accelerometer axes
//   crd_start, crd_x, crd_y   request pulse and signed 24-bit operands to the CORDIC
//   crd_done, crd_angle,
//   crd_magnitude             CORDIC result handshake (done may be a level or a pulse)
//   roll, pitch, tilt_valid   signed 24-bit results, updated together with a one-cycle pulse
//   busy                      high whenever the sequencer is not idle
//   overrun, timeout_err      sticky error flags, cleared only by reset

module accel_tilt_seq #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned MAG_COMP    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    input  logic signed [15:0] ax,
    input  logic signed [15:0] ay,
    input  logic signed [15:0] az,
    output logic               crd_start,
    output logic signed [23:0] crd_x,
    output logic signed [23:0] crd_y,
    input  logic               crd_done,
    input  logic signed [23:0] crd_angle,
    input  logic signed [23:0] crd_magnitude,
    output logic signed [23:0] roll,
    output logic signed [23:0] pitch,
    output logic               tilt_valid,
    output logic               busy,
    output logic               overrun,
    output logic               timeout_err
);

    // Counter only has to reach TIMEOUT_CYC-1 (one count per wait cycle).
    localparam int unsigned CntW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRollReq,
        StRollWait,
        StPitchReq,
        StPitchWait,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic signed [15:0] ax_q, ax_d;
    logic signed [23:0] crd_x_q, crd_x_d;
    logic signed [23:0] crd_y_q, crd_y_d;
    logic signed [23:0] roll_tmp_q, roll_tmp_d;
    logic signed [23:0] pitch_tmp_q, pitch_tmp_d;
    logic signed [23:0] roll_q, roll_d;
    logic signed [23:0] pitch_q, pitch_d;
    logic               tilt_valid_q, tilt_valid_d;
    logic               overrun_q, overrun_d;
    logic               timeout_err_q, timeout_err_d;
    logic [CntW-1:0]    wait_cnt_q, wait_cnt_d;

    logic               wait_accept;
    logic               wait_expired;

    // Removes the ~1.647 CORDIC gain: 1/2 + 1/8 - 1/64 - 1/512 ~= 0.6074.
    // Each term is floored on its own by the arithmetic shift.
    function automatic logic signed [23:0] mag_comp(input logic signed [23:0] m);
        if (MAG_COMP != 0) begin
            return (m >>> 1) + (m >>> 3) - (m >>> 6) - (m >>> 9);
        end
        return m;
    endfunction

    // The first wait cycle may still see the done level of the previous operation,
    // so a done is only accepted once the counter has moved off zero.
    assign wait_accept  = crd_done && (wait_cnt_q != '0);
    assign wait_expired = !wait_accept && (wait_cnt_q == CntLast);

    always_comb begin
        state_d       = state_q;
        ax_d          = ax_q;
        crd_x_d       = crd_x_q;
        crd_y_d       = crd_y_q;
        roll_tmp_d    = roll_tmp_q;
        pitch_tmp_d   = pitch_tmp_q;
        roll_d        = roll_q;
        pitch_d       = pitch_q;
        tilt_valid_d  = 1'b0;
        overrun_d     = overrun_q;
        timeout_err_d = timeout_err_q;
        wait_cnt_d    = wait_cnt_q;
        crd_start     = 1'b0;

        // Any strobe outside idle (including the DONE cycle) is dropped.
        if (sample_valid && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (sample_valid) begin
                    ax_d    = ax;
                    crd_x_d = {{8{az[15]}}, az};
                    crd_y_d = {{8{ay[15]}}, ay};
                    state_d = StRollReq;
                end
            end
            StRollReq: begin
                crd_start  = 1'b1;
                wait_cnt_d = '0;
                state_d    = StRollWait;
            end
            StRollWait: begin
                if (wait_accept) begin
                    roll_tmp_d = crd_angle;
                    // crd_x doubles as the compensated-magnitude temporary.
                    crd_x_d    = mag_comp(crd_magnitude);
                    // 24-bit negate, so ax = -32768 yields +32768 without overflow.
                    crd_y_d    = 24'sd0 - {{8{ax_q[15]}}, ax_q};
                    state_d    = StPitchReq;
                end else if (wait_expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + CntW'(1);
                end
            end
            StPitchReq: begin
                crd_start  = 1'b1;
                wait_cnt_d = '0;
                state_d    = StPitchWait;
            end
            StPitchWait: begin
                if (wait_accept) begin
                    pitch_tmp_d = crd_angle;
                    state_d     = StDone;
                end else if (wait_expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + CntW'(1);
                end
            end
            StDone: begin
                // Both angles move to the outputs together; the pulse lands with them.
                roll_d       = roll_tmp_q;
                pitch_d      = pitch_tmp_q;
                tilt_valid_d = 1'b1;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            ax_q          <= '0;
            crd_x_q       <= '0;
            crd_y_q       <= '0;
            roll_tmp_q    <= '0;
            pitch_tmp_q   <= '0;
            roll_q        <= '0;
            pitch_q       <= '0;
            tilt_valid_q  <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            ax_q          <= ax_d;
            crd_x_q       <= crd_x_d;
            crd_y_q       <= crd_y_d;
            roll_tmp_q    <= roll_tmp_d;
            pitch_tmp_q   <= pitch_tmp_d;
            roll_q        <= roll_d;
            pitch_q       <= pitch_d;
            tilt_valid_q  <= tilt_valid_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign crd_x       = crd_x_q;
    assign crd_y       = crd_y_q;
    assign roll        = roll_q;
    assign pitch       = pitch_q;
    assign tilt_valid  = tilt_valid_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_accel_tilt_seq.sv
// Bench for accel_tilt_seq: a CORDIC stub answers each crd_start after a programmable
// delay (or holds done high, or never answers); expected requests and results are queued
// when a sample is driven and compared when the DUT issues requests / pulses tilt_valid.

module tb_accel_tilt_seq;

    logic               clk;
    logic               rst;
    logic               sample_valid;
    logic signed [15:0] ax, ay, az;
    logic               crd_start;
    logic signed [23:0] crd_x, crd_y;
    logic               crd_done;
    logic signed [23:0] crd_angle, crd_magnitude;
    logic signed [23:0] roll, pitch;
    logic               tilt_valid, busy, overrun, timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Stub controls
    int stub_delay = 5;
    bit stub_hold  = 1'b0;
    bit stub_mute  = 1'b0;
    int cd         = 0;
    bit prev_start = 1'b0;

    int last_roll  = 0;
    int last_pitch = 0;

    // Scoreboard queues
    int exp_req_x[$];
    int exp_req_y[$];
    int exp_roll[$];
    int exp_pitch[$];
    int exp_t0[$];
    int exp_lat[$];
    int resp_ang[$];
    int resp_mag[$];

    accel_tilt_seq #(
        .TIMEOUT_CYC(10),
        .MAG_COMP   (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .ax           (ax),
        .ay           (ay),
        .az           (az),
        .crd_start    (crd_start),
        .crd_x        (crd_x),
        .crd_y        (crd_y),
        .crd_done     (crd_done),
        .crd_angle    (crd_angle),
        .crd_magnitude(crd_magnitude),
        .roll         (roll),
        .pitch        (pitch),
        .tilt_valid   (tilt_valid),
        .busy         (busy),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int floor_div(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int comp_model(input int m);
        return floor_div(m, 2) + floor_div(m, 8) - floor_div(m, 64) - floor_div(m, 512);
    endfunction

    // mode 0: sample expected to be dropped; 1: only the roll request is expected;
    // 2: full sequence with result after lat cycles.
    task automatic send(input int sx, input int sy, input int sz, input int mode,
                        input int a1, input int m1, input int a2, input int m2,
                        input int lat);
        if (mode >= 1) begin
            exp_req_x.push_back(sz);
            exp_req_y.push_back(sy);
            resp_ang.push_back(a1);
            resp_mag.push_back(m1);
        end
        if (mode == 2) begin
            exp_req_x.push_back(comp_model(m1));
            exp_req_y.push_back(-sx);
            resp_ang.push_back(a2);
            resp_mag.push_back(m2);
            exp_roll.push_back(a1);
            exp_pitch.push_back(a2);
            exp_t0.push_back(cyc);
            exp_lat.push_back(lat);
            last_roll  = a1;
            last_pitch = a2;
        end
        ax           = 16'(sx);
        ay           = 16'(sy);
        az           = 16'(sz);
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            if (!busy && exp_roll.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_idle_bound", 0, 1);
    endtask

    // Stub CORDIC plus output monitor, evaluated mid-cycle.
    task automatic monitor_step();
        if (stub_hold) begin
            crd_done = 1'b1;
        end else if (stub_mute) begin
            crd_done = 1'b0;
        end else if (cd > 0) begin
            cd       = cd - 1;
            crd_done = (cd == 0);
        end else begin
            crd_done = 1'b0;
        end

        if (crd_start) begin
            check("start_not_back_to_back", int'(prev_start), 0);
            if (exp_req_x.size() == 0) begin
                check("unexpected_crd_start", 1, 0);
            end else begin
                check("crd_x", int'($signed(crd_x)), exp_req_x.pop_front());
                check("crd_y", int'($signed(crd_y)), exp_req_y.pop_front());
            end
            if (resp_ang.size() > 0) begin
                crd_angle     = 24'(resp_ang.pop_front());
                crd_magnitude = 24'(resp_mag.pop_front());
            end
            cd = stub_delay;
        end
        prev_start = crd_start;

        if (tilt_valid) begin
            if (exp_roll.size() == 0) begin
                check("unexpected_tilt_valid", 1, 0);
            end else begin
                check("roll", int'($signed(roll)), exp_roll.pop_front());
                check("pitch", int'($signed(pitch)), exp_pitch.pop_front());
                check("latency", cyc - exp_t0.pop_front(), exp_lat.pop_front());
            end
        end
    endtask

    initial begin
        rst           = 1'b0;
        sample_valid  = 1'b0;
        ax            = '0;
        ay            = '0;
        az            = '0;
        crd_done      = 1'b0;
        crd_angle     = '0;
        crd_magnitude = '0;

        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_crd_start", int'(crd_start), 0);
        check("rst_crd_x", int'($signed(crd_x)), 0);
        check("rst_crd_y", int'($signed(crd_y)), 0);
        check("rst_roll", int'($signed(roll)), 0);
        check("rst_pitch", int'($signed(pitch)), 0);
        check("rst_tilt_valid", int'(tilt_valid), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_timeout_err", int'(timeout_err), 0);

        // Nominal, sample in the first cycle after reset release.
        rst        = 1'b0;
        stub_delay = 5;
        send(500, 100, 16384, 2, 1000, 26984, 2000, 26984, 14);
        wait_idle(40);

        // Most negative ax: pitch request y must be +32768.
        send(-32768, 0, 0, 2, 77, 0, -5, 123, 14);
        wait_idle(40);

        // Done held high throughout: each wait lasts two cycles, negative magnitude.
        stub_hold = 1'b1;
        send(1, -7, -9, 2, 300, -1000, 400, 0, 8);
        wait_idle(40);
        stub_hold = 1'b0;
        check("overrun_before", int'(overrun), 0);

        // Second strobe three cycles after the first is dropped.
        stub_delay = 3;
        send(-200, 50, 9000, 2, -321, 4000, 654, 0, 10);
        repeat (2) @(posedge clk);
        #1;
        send(7777, 7777, 7777, 0, 0, 0, 0, 0, 0);
        wait_idle(40);
        check("overrun_after", int'(overrun), 1);

        // Strobe exactly in the DONE cycle is dropped as well.
        stub_delay = 2;
        send(10, 20, 30, 2, 11, 2048, 22, 0, 8);
        repeat (6) @(posedge clk);
        #1;
        check("busy_in_done", int'(busy), 1);
        send(99, 99, 99, 0, 0, 0, 0, 0, 0);
        wait_idle(40);

        // No done ever: timeout, back to idle, outputs untouched.
        check("timeout_before", int'(timeout_err), 0);
        stub_mute = 1'b1;
        send(3, 4, 5, 1, 0, 0, 0, 0, 0);
        repeat (20) @(posedge clk);
        #1;
        check("timeout_err", int'(timeout_err), 1);
        check("timeout_busy", int'(busy), 0);
        check("timeout_roll", int'($signed(roll)), last_roll);
        check("timeout_pitch", int'($signed(pitch)), last_pitch);
        stub_mute = 1'b0;

        // Reset in ROLL_WAIT, late done afterwards must be ignored.
        stub_delay = 6;
        send(40, 50, 60, 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_roll", int'($signed(roll)), 0);
        check("post_rst_pitch", int'($signed(pitch)), 0);
        check("post_rst_crd_x", int'($signed(crd_x)), 0);
        check("post_rst_crd_y", int'($signed(crd_y)), 0);
        check("post_rst_overrun", int'(overrun), 0);
        check("post_rst_timeout", int'(timeout_err), 0);

        // Normal operation after the abort.
        stub_delay = 3;
        send(-200, -300, 1234, 2, -111, 5000, 222, 0, 10);
        wait_idle(40);
        repeat (3) @(posedge clk);
        #1;
        check("hold_roll", int'($signed(roll)), last_roll);
        check("hold_pitch", int'($signed(pitch)), last_pitch);
        check("req_queue_empty", exp_req_x.size(), 0);
        check("result_queue_empty", exp_roll.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
